// File: rtl/fp16_div_pkg.sv
// Shared FP16 constants for the fp16 arithmetic library.
package fp16_div_pkg;
  localparam int FP16_W      = 16;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MANT_W = 10;

  localparam logic [15:0] FP16_ZERO     = 16'h0000;
  localparam logic [15:0] FP16_SNAN     = 16'h7D00;
  localparam int          FP16_EXP_BIAS = 15;
  localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;
endpackage

// File: rtl/fp16_div_classify.sv
// Combinational FP16 operand classifier: fields, class flags, leading-zero count.
module fp16_classify
  import fp16_div_pkg::*;
(
  input  logic [FP16_W-1:0]      x,
  output logic                   sign,
  output logic [FP16_EXP_W-1:0]  exp,
  output logic [FP16_MANT_W:0]   mant,
  output logic                   is_nan,
  output logic                   is_inf,
  output logic                   is_zero,
  output logic                   is_sub,
  output logic [3:0]             lz
);
  logic exp_max, exp_min, frac_nz;

  assign sign    = x[15];
  assign exp     = x[14:10];
  assign exp_max = (x[14:10] == FP16_EXP_MAX);
  assign exp_min = (x[14:10] == 5'd0);
  assign frac_nz = (x[9:0] != 10'd0);
  assign mant    = {!exp_min, x[9:0]};
  assign is_nan  = exp_max && frac_nz;
  assign is_inf  = exp_max && !frac_nz;
  assign is_zero = exp_min && !frac_nz;
  assign is_sub  = exp_min && frac_nz;

  // Highest set bit wins; an all-zero mantissa reports 11.
  always_comb begin
    lz = 4'd11;
    for (int i = 0; i < 11; i++)
      if (mant[i]) lz = 4'(10 - i);
  end
endmodule

// File: rtl/fp16_div.sv
// Iterative FP16 divider, radix-2 restoring, truncating, valid/ready on both ends.
module fp16_div
  import fp16_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        flag_dz
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] NORM = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] PACK = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic        sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sub_a, sub_b;
  logic [4:0]  ea, eb, ea_eff, eb_eff;
  logic [10:0] ma, mb;
  logic [3:0]  lza, lzb;

  fp16_classify u_cls_a (.x(a), .sign(sa), .exp(ea), .mant(ma), .is_nan(nan_a),
                         .is_inf(inf_a), .is_zero(zero_a), .is_sub(sub_a), .lz(lza));
  fp16_classify u_cls_b (.x(b), .sign(sb), .exp(eb), .mant(mb), .is_nan(nan_b),
                         .is_inf(inf_b), .is_zero(zero_b), .is_sub(sub_b), .lz(lzb));

  logic [2:0]         state;
  logic               sign_r;
  logic signed [6:0]  e_r;
  logic [10:0]        ma_r, mb_r;
  logic [3:0]         lza_r, lzb_r, cnt;
  logic [11:0]        rem;
  logic [12:0]        q;
  logic [15:0]        result_r;
  logic               dz_r;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
  assign flag_dz   = dz_r;
  assign ea_eff    = sub_a ? 5'd1 : ea;
  assign eb_eff    = sub_b ? 5'd1 : eb;

  logic        spec_hit, spec_dz, s_q;
  logic [15:0] spec_res;
  always_comb begin
    s_q      = sa ^ sb;
    spec_hit = 1'b1;
    spec_dz  = 1'b0;
    spec_res = FP16_ZERO;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
      spec_res = FP16_SNAN;
    else if (inf_a)
      spec_res = {s_q, FP16_EXP_MAX, 10'd0};
    else if (zero_b) begin
      spec_res = {s_q, FP16_EXP_MAX, 10'd0};
      spec_dz  = 1'b1;
    end else if (zero_a || inf_b)
      spec_res = {s_q, 15'd0};
    else
      spec_hit = 1'b0;
  end

  logic        qbit;
  logic [11:0] rem_sub;
  assign qbit    = (rem >= {1'b0, mb_r});
  assign rem_sub = qbit ? (rem - {1'b0, mb_r}) : rem;

  // Pack: renormalise a quotient in (0.5,1), then saturate to inf or denormalise.
  logic [9:0]        frac_n, sub_m;
  logic signed [6:0] e_n, sh_raw;
  logic [3:0]        sh;
  logic [15:0]       packed_res;
  always_comb begin
    frac_n = q[12] ? q[11:2] : q[10:1];
    e_n    = q[12] ? e_r : (e_r - 7'sd1);
    sh_raw = 7'sd1 - e_n;
    sh     = (sh_raw > 7'sd11) ? 4'd11 : sh_raw[3:0];
    sub_m  = 10'({1'b1, frac_n} >> sh);
    if (e_n >= 7'sd31)
      packed_res = {sign_r, FP16_EXP_MAX, 10'd0};
    else if (e_n <= 7'sd0)
      packed_res = {sign_r, 5'd0, sub_m};
    else
      packed_res = {sign_r, e_n[4:0], frac_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign_r   <= 1'b0;
      e_r      <= 7'sd0;
      ma_r     <= 11'd0;
      mb_r     <= 11'd0;
      lza_r    <= 4'd0;
      lzb_r    <= 4'd0;
      cnt      <= 4'd0;
      rem      <= 12'd0;
      q        <= 13'd0;
      result_r <= FP16_ZERO;
      dz_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_r <= s_q;
          if (spec_hit) begin
            result_r <= spec_res;
            dz_r     <= spec_dz;
            state    <= DONE;
          end else begin
            ma_r  <= ma;
            mb_r  <= mb;
            lza_r <= lza;
            lzb_r <= lzb;
            e_r   <= $signed({2'b00, ea_eff}) - $signed({2'b00, eb_eff}) + 7'sd15;
            state <= NORM;
          end
        end
        NORM: begin
          rem   <= {1'b0, ma_r << lza_r};
          mb_r  <= mb_r << lzb_r;
          e_r   <= e_r - $signed({3'b000, lza_r}) + $signed({3'b000, lzb_r});
          q     <= 13'd0;
          cnt   <= 4'd0;
          state <= DIV;
        end
        DIV: begin
          rem <= rem_sub << 1;
          q   <= {q[11:0], qbit};
          if (cnt == 4'd12) state <= PACK;
          else              cnt   <= cnt + 4'd1;
        end
        PACK: begin
          result_r <= packed_res;
          dz_r     <= 1'b0;
          state    <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_div.sv
// Directed and random self-checking bench for fp16_div.
module tb_fp16_div;
  import fp16_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        flag_dz;

  int n_assert = 0;
  int n_fail   = 0;

  fp16_div dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
                .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
                .result(result), .flag_dz(flag_dz));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating reference for finite nonzero operands, from the real-valued quotient.
  function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    longint ma, mb, qq;
    int     ex, ey, p, ee, s;
    logic   sg;
    sg = x[15] ^ y[15];
    ma = (x[14:10] == 5'd0) ? longint'(x[9:0]) : longint'(x[9:0]) + 1024;
    mb = (y[14:10] == 5'd0) ? longint'(y[9:0]) : longint'(y[9:0]) + 1024;
    ex = (x[14:10] == 5'd0) ? -24 : int'(x[14:10]) - 25;
    ey = (y[14:10] == 5'd0) ? -24 : int'(y[14:10]) - 25;
    qq = (ma <<< 30) / mb;
    p  = 0;
    for (int i = 0; i < 62; i++) if (qq[i]) p = i;
    ee = p + ex - ey - 30;
    if (ee >= 16)  return {sg, 5'h1F, 10'h0};
    if (ee >= -14) return {sg, 5'(ee + 15), 10'((qq >> (p - 10)) & 1023)};
    s = 6 - ex + ey;
    if (s >= 62) return {sg, 15'h0};
    return {sg, 5'd0, 10'(qq >> s)};
  endfunction

  logic [15:0] res;
  logic        dz;
  int          lat;

  task automatic run(input logic [15:0] ta, input logic [15:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    dz  = flag_dz;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [15:0] held, ra, rb;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'(FP16_ZERO));
    chk("reset_flag_dz", 32'(flag_dz), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    run(16'h4200, 16'h4000);
    chk("t1_result", 32'(res), 32'h3E00);
    chk("t1_dz", 32'(dz), 32'd0);
    chk("t1_latency", 32'(lat), 32'd15);

    run(16'h3C00, 16'h4200);
    chk("t2_third", 32'(res), 32'h3555);
    run(16'hBC00, 16'h4200);
    chk("t2_neg_third", 32'(res), 32'hB555);
    chk("t2_latency", 32'(lat), 32'd15);

    run(16'h3C00, 16'h0000);
    chk("t3_pos_dz_res", 32'(res), 32'h7C00);
    chk("t3_pos_dz_flag", 32'(dz), 32'd1);
    chk("t3_pos_dz_lat", 32'(lat), 32'd0);
    run(16'hBC00, 16'h0000);
    chk("t3_neg_dz_res", 32'(res), 32'hFC00);
    chk("t3_neg_dz_flag", 32'(dz), 32'd1);
    run(16'h0000, 16'h0000);
    chk("t3_zz_nan_exp", 32'(res[14:10]), 32'h1F);
    chk("t3_zz_nan_mant", 32'(res[9:0] != 10'd0), 32'd1);
    chk("t3_zz_flag", 32'(dz), 32'd0);
    chk("t3_zz_lat", 32'(lat), 32'd0);
    run(16'h7E00, 16'h3C00);
    chk("t3_nan_in_exp", 32'(res[14:10]), 32'h1F);
    chk("t3_nan_in_mant", 32'(res[9:0] != 10'd0), 32'd1);
    chk("t3_nan_in_lat", 32'(lat), 32'd0);
    run(16'hFC00, 16'h3C00);
    chk("t3_inf_fin", 32'(res), 32'hFC00);
    run(16'h3C00, 16'h7C00);
    chk("t3_fin_inf", 32'(res), 32'h0000);

    run(16'h0200, 16'h4000);
    chk("t4_subnormal", 32'(res), 32'h0100);
    run(16'h0001, 16'h4000);
    chk("t4_underflow", 32'(res), 32'h0000);
    run(16'h7BFF, 16'h0001);
    chk("t4_overflow", 32'(res), 32'h7C00);
    chk("t4_overflow_dz", 32'(dz), 32'd0);
    chk("t4_overflow_lat", 32'(lat), 32'd15);

    // Backpressure: hold the result while new operands are offered.
    @(negedge clk);
    a = 16'h4200; b = 16'h4000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_first_result", 32'(result), 32'h3E00);
    held = result;
    a = 16'h3C00; b = 16'h0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_result_%0d", i), 32'(result), 32'(held));
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);
    chk("bp_result_kept", 32'(result), 32'h3E00);
    run(16'hC400, 16'h4000);
    chk("bp_next_op", 32'(res), 32'hC000);

    // Reset during the seventh DIV cycle.
    @(negedge clk);
    a = 16'h4200; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_mid_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", 32'(result), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (ra[14:10] == 5'h1F) ra[14:10] = 5'(($urandom_range(0, 30)));
      if (rb[14:10] == 5'h1F) rb[14:10] = 5'(($urandom_range(0, 30)));
      if (i % 4 == 0) ra[14:10] = 5'd0;
      if (i % 7 == 0) rb[14:10] = 5'd0;
      if (ra[14:0] == 15'd0) ra[0] = 1'b1;
      if (rb[14:0] == 15'd0) rb[0] = 1'b1;
      run(ra, rb);
      chk($sformatf("rand_%0d_%h_%h", i, ra, rb), 32'(res), 32'(ref_div(ra, rb)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
